// File: rtl/wave_ctrl_multi_pkg.sv
// Shared definitions for the multi-channel wave control path.
// Contents: the instruction opcodes, the bit positions of the instruction
// fields, and the per-channel timer state type.
package wave_ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSH  = 4'h1;
    localparam logic [3:0] OP_FLUSH = 4'h2;

    // Instruction layout: [31:28] opcode, [27:24] channel, [23:8] delay, [7:0] codeword
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int CH_MSB  = 27;
    localparam int CH_LSB  = 24;
    localparam int DLY_MSB = 23;
    localparam int DLY_LSB = 8;
    localparam int CW_MSB  = 7;
    localparam int CW_LSB  = 0;

    typedef enum logic {IDLE, COUNT} tstate_e;

endpackage

// File: rtl/wave_ctrl_multi_if.sv
// Instruction handshake bundle between fetch/decode and the wave controller.
//   instr_data  : 32-bit wave instruction
//   instr_valid : instruction present
//   instr_ready : controller accepts when valid & ready at the clock edge
interface wave_ctrl_multi_if;
    logic [31:0] instr_data;
    logic        instr_valid;
    logic        instr_ready;

    modport master (output instr_data, output instr_valid, input  instr_ready);
    modport slave  (input  instr_data, input  instr_valid, output instr_ready);
endinterface

// File: rtl/wave_ctrl_multi_chan.sv
// One output channel: a FIFO of {delay, codeword} entries feeding a
// countdown timer that emits a one-cycle trigger when the delay expires.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write din into the FIFO (never asserted while full)
//   flush     : empty the FIFO and abort any countdown
//   trg_valid : one-cycle trigger strobe; trg_cw holds its last value
//   empty, full, busy : FIFO status and "timer counting" flag
module wave_chan
    import wave_ctrl_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CW_W   = 8,
    parameter int TIME_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   flush,
    input  logic [TIME_W+CW_W-1:0] din,
    output logic                   trg_valid,
    output logic [CW_W-1:0]        trg_cw,
    output logic                   empty,
    output logic                   full,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);

    logic [TIME_W+CW_W-1:0] mem [DEPTH];
    // Extra pointer MSB tells full from empty once the pointers wrap.
    logic [AW:0]            wptr, rptr;
    logic [TIME_W-1:0]      cnt;
    logic [CW_W-1:0]        cw_q;
    tstate_e                state, state_d;
    logic                   pop, fire;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign busy  = (state == COUNT);

    // Flush dominates: it suppresses both the pop and the trigger.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        fire    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    pop     = 1'b1;
                    state_d = COUNT;
                end
                COUNT: if (cnt == '0) begin
                    fire    = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            cw_q      <= '0;
            trg_valid <= 1'b0;
            trg_cw    <= '0;
        end else begin
            state     <= state_d;
            trg_valid <= fire;
            if (fire) trg_cw <= cw_q;
            if (push) wptr <= wptr + 1'b1;
            // push and flush never target the same channel in one cycle
            if (flush) begin
                rptr <= wptr;
            end else if (pop) begin
                rptr        <= rptr + 1'b1;
                {cnt, cw_q} <= mem[rptr[AW-1:0]];
            end else if (state == COUNT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_ctrl_multi.sv
// Multi-channel wave controller: decodes 32-bit wave instructions and
// dispatches PUSH/FLUSH to N_CH independent channels.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   instr      : instruction handshake (slave side)
//   trg_valid  : per-channel trigger strobe
//   trg_cw     : per-channel codeword, channel k at [k*CW_W +: CW_W]
//   fifo_empty, fifo_full, busy : per-channel status
//   err        : sticky flag for illegal opcode or out-of-range channel
module wave_ctrl_multi
    import wave_ctrl_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int DEPTH  = 8,
    parameter int CW_W   = 8,
    parameter int TIME_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    wave_ctrl_multi_if.slave       instr,
    output logic [N_CH-1:0]        trg_valid,
    output logic [N_CH*CW_W-1:0]   trg_cw,
    output logic [N_CH-1:0]        fifo_empty,
    output logic [N_CH-1:0]        fifo_full,
    output logic [N_CH-1:0]        busy,
    output logic                   err
);
    logic [3:0]             opc, ch;
    logic                   legal_ch, legal_op, full_sel, accept;
    logic [TIME_W+CW_W-1:0] din;

    assign opc      = instr.instr_data[OPC_MSB:OPC_LSB];
    assign ch       = instr.instr_data[CH_MSB:CH_LSB];
    assign legal_ch = 32'(ch) < N_CH;
    assign legal_op = (opc == OP_NOP) || (opc == OP_PUSH) || (opc == OP_FLUSH);
    assign din      = {instr.instr_data[DLY_LSB +: TIME_W], instr.instr_data[CW_LSB +: CW_W]};

    // Full flag of the addressed channel; 0 for out-of-range channels,
    // which are always accepted and dropped.
    always_comb begin
        full_sel = 1'b0;
        for (int k = 0; k < N_CH; k++)
            if (ch == 4'(k)) full_sel = fifo_full[k];
    end

    assign instr.instr_ready = !(opc == OP_PUSH && full_sel);
    assign accept            = instr.instr_valid && instr.instr_ready;

    always_ff @(posedge clk) begin
        if (rst)                                     err <= 1'b0;
        else if (accept && (!legal_op || !legal_ch)) err <= 1'b1;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        wave_chan #(.DEPTH(DEPTH), .CW_W(CW_W), .TIME_W(TIME_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .push      (accept && opc == OP_PUSH  && ch == 4'(g)),
            .flush     (accept && opc == OP_FLUSH && ch == 4'(g)),
            .din       (din),
            .trg_valid (trg_valid[g]),
            .trg_cw    (trg_cw[g*CW_W +: CW_W]),
            .empty     (fifo_empty[g]),
            .full      (fifo_full[g]),
            .busy      (busy[g])
        );
    end

endmodule

// File: tb/tb_wave_ctrl_multi.sv
// Directed bench for wave_ctrl_multi (N_CH=2). Each accepted PUSH puts the
// expected trigger edge and codeword on a per-channel queue; a negedge
// monitor pops and compares whenever a trigger strobe appears.
module tb_wave_ctrl_multi;
    localparam int N_CH = 2;
    localparam int CW_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wave_ctrl_multi_if ifc ();
    logic [N_CH-1:0]      trg_valid, fifo_empty, fifo_full, busy;
    logic [N_CH*CW_W-1:0] trg_cw;
    logic                 err;

    wave_ctrl_multi #(.N_CH(N_CH), .DEPTH(8), .CW_W(CW_W), .TIME_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (ifc),
        .trg_valid  (trg_valid),
        .trg_cw     (trg_cw),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edg;
        logic [7:0] cw;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   last_trg [N_CH];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Trigger monitor: every strobe must match the head of its channel queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (trg_valid[0]) begin
                chk("trg0_expected", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("trg0_edge", 64'(edge_n), 64'(e.edg));
                    chk("trg0_cw", 64'(trg_cw[7:0]), 64'(e.cw));
                end
            end
            if (trg_valid[1]) begin
                chk("trg1_expected", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("trg1_edge", 64'(edge_n), 64'(e.edg));
                    chk("trg1_cw", 64'(trg_cw[15:8]), 64'(e.cw));
                end
            end
        end
    end

    function automatic void model_clear(input int ch);
        if (ch == 0) q0.delete(); else q1.delete();
        last_trg[ch] = -100;
    endfunction

    // Drive one instruction for one cycle; check acceptance; update model.
    task automatic op(input logic [3:0] opc, input logic [3:0] ch, input logic [15:0] d,
                      input logic [7:0] cw, input bit exp_acc, input string tag);
        bit   acc;
        int   t, pop_e;
        exp_t e;
        @(negedge clk);
        ifc.instr_data  = {opc, ch, d, cw};
        ifc.instr_valid = 1'b1;
        #1 acc = ifc.instr_ready;
        @(posedge clk);
        #1 t = edge_n;
        ifc.instr_valid = 1'b0;
        chk(tag, 64'(acc), 64'(exp_acc));
        if (acc && ch < 4'(N_CH)) begin
            if (opc == 4'h1) begin
                // pop one edge after the push, or one edge after the previous trigger
                pop_e        = (t + 1 > last_trg[ch] + 1) ? t + 1 : last_trg[ch] + 1;
                e.edg        = pop_e + 1 + int'(d);
                e.cw         = cw;
                last_trg[ch] = e.edg;
                if (ch == 4'd0) q0.push_back(e); else q1.push_back(e);
            end else if (opc == 4'h2) begin
                model_clear(int'(ch));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_clear(0);
        model_clear(1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int bound, input string tag);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, 64'(fifo_empty), 64'h3);
        chk({tag, "_full"},  64'(fifo_full),  64'h0);
        chk({tag, "_busy"},  64'(busy),       64'h0);
        chk({tag, "_trgv"},  64'(trg_valid),  64'h0);
        chk({tag, "_trgcw"}, 64'(trg_cw),     64'h0);
        chk({tag, "_err"},   64'(err),        64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        ifc.instr_data  = '0;
        ifc.instr_valid = 1'b0;
        model_clear(0);
        model_clear(1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: reset, idle
        repeat (10) @(negedge clk);
        chk_reset_state("rst1");
        chk("rst1_ready", 64'(ifc.instr_ready), 64'd1);

        // 2: single push, delay 3
        op(4'h1, 4'd0, 16'd3, 8'hA5, 1'b1, "t2_acc");
        bcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy[0]) bcnt++;
        end
        chk("t2_busy_cycles", 64'(bcnt), 64'd4);
        chk("t2_drained", 64'(q0.size()), 64'd0);
        chk("t2_cw_hold", 64'(trg_cw[7:0]), 64'hA5);

        // 3: fill ch1, full back-pressure, ch0 unaffected
        for (int i = 0; i < 9; i++)
            op(4'h1, 4'd1, 16'd20, 8'h10 + 8'(i), 1'b1, "t3_acc");
        chk("t3_full1", 64'(fifo_full[1]), 64'd1);
        chk("t3_nempty1", 64'(fifo_empty[1]), 64'd0);
        op(4'h1, 4'd1, 16'd20, 8'hEE, 1'b0, "t3_blocked");
        op(4'h1, 4'd0, 16'd1, 8'h3C, 1'b1, "t3_ch0_acc");
        drain(300, "t3_drained");
        chk("t3_empty_after", 64'(fifo_empty), 64'h3);

        // 4: flush while busy with one entry still queued
        op(4'h1, 4'd0, 16'd10, 8'h11, 1'b1, "t4_acc_a");
        op(4'h1, 4'd0, 16'd5, 8'h12, 1'b1, "t4_acc_b");
        repeat (3) @(negedge clk);
        chk("t4_busy_pre", 64'(busy[0]), 64'd1);
        op(4'h2, 4'd0, 16'd0, 8'h00, 1'b1, "t4_flush_acc");
        chk("t4_busy_post", 64'(busy[0]), 64'd0);
        chk("t4_empty_post", 64'(fifo_empty[0]), 64'd1);
        op(4'h1, 4'd0, 16'd0, 8'h22, 1'b1, "t4_acc_c");
        drain(20, "t4_drained");
        repeat (15) @(negedge clk);

        // 5: illegal opcode and out-of-range channel
        op(4'h7, 4'd0, 16'd0, 8'h00, 1'b1, "t5_illop_acc");
        chk("t5_err_set", 64'(err), 64'd1);
        op(4'h1, 4'd5, 16'd1, 8'h99, 1'b1, "t5_badch_acc");
        chk("t5_no_fifo_change", 64'(fifo_empty), 64'h3);
        repeat (5) @(negedge clk);
        chk("t5_err_sticky", 64'(err), 64'd1);
        do_reset();
        chk("t5_err_clr", 64'(err), 64'd0);

        // 6: both channels in adjacent cycles, then reset mid-count
        op(4'h1, 4'd0, 16'd2, 8'hAA, 1'b1, "t6_acc0");
        op(4'h1, 4'd1, 16'd2, 8'h55, 1'b1, "t6_acc1");
        drain(20, "t6_drained");
        op(4'h1, 4'd0, 16'd30, 8'h77, 1'b1, "t6_acc2");
        op(4'h1, 4'd1, 16'd30, 8'h88, 1'b1, "t6_acc3");
        repeat (10) @(negedge clk);
        chk("t6_busy_pre", 64'(busy), 64'h3);
        do_reset();
        chk_reset_state("t6_rst");
        repeat (40) @(negedge clk);
        chk_reset_state("t6_quiet");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
